jt49_mixn: RTL

//  Parametrised N-channel PSG output mixer. Each frame it time-multiplexes CH
//  5-bit log volumes through a single jt49_exp instance and publishes per-channel

---
 rtl/jt49_mixn.sv | 125 ++++++++++++
 1 files changed

// File: rtl/jt49_mixn.sv
// N-channel PSG mixer: one shared log-to-linear converter is time-multiplexed
// across the channels, producing per-channel levels, their sum and a strobe.

module jt49_exp (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] comp,
    input  logic [4:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] TAB0 [0:31] = '{
        8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
        8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd13,  8'd16,
        8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
        8'd76,  8'd90,  8'd107, 8'd128, 8'd152, 8'd180, 8'd214, 8'd255};
    localparam logic [7:0] TAB1 [0:31] = '{
        8'd0,   8'd8,   8'd9,   8'd10,  8'd11,  8'd13,  8'd14,  8'd16,
        8'd18,  8'd20,  8'd23,  8'd25,  8'd28,  8'd32,  8'd36,  8'd40,
        8'd45,  8'd51,  8'd57,  8'd64,  8'd72,  8'd80,  8'd90,  8'd101,
        8'd114, 8'd128, 8'd143, 8'd161, 8'd180, 8'd202, 8'd227, 8'd255};
    localparam logic [7:0] TAB2 [0:31] = '{
        8'd0,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,
        8'd1,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,   8'd5,   8'd6,
        8'd8,   8'd10,  8'd13,  8'd16,  8'd20,  8'd26,  8'd32,  8'd40,
        8'd51,  8'd64,  8'd81,  8'd102, 8'd128, 8'd161, 8'd203, 8'd255};

    // Curve 3 is a plain linear ramp, clamped so full scale lands on 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'd0;
        end else begin
            case (comp)
                2'b00:   dout <= TAB0[din];
                2'b01:   dout <= TAB1[din];
                2'b10:   dout <= TAB2[din];
                default: dout <= (din == 5'd31) ? 8'd255 : {din, 3'b000};
            endcase
        end
    end
endmodule

module jt49_mixn #(
    parameter  int         CH   = 3,
    parameter  logic [1:0] COMP = 2'b00,
    localparam int         AW   = 8 + $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic [5*CH-1:0] log_in,
    input  logic [CH-1:0]   ch_en,
    output logic [8*CH-1:0] lin_out,
    output logic [AW-1:0]   sound,
    output logic            sample
);
    localparam int SW = $clog2(CH + 1);

    logic [SW-1:0]   r_slot;
    logic [4:0]      r_log;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_sound;
    logic [8*CH-1:0] r_linOut;
    logic            r_sample;
    logic [4:0]      w_logSel;
    logic [4:0]      w_logNext;
    logic [7:0]      w_lin;
    logic            w_chSlot;

    always_comb begin
        w_logSel = 5'd0;
        for (int k = 0; k < CH; k++) begin
            if (r_slot == SW'(k)) begin
                w_logSel = ch_en[k] ? log_in[5*k +: 5] : 5'd0;
            end
        end
    end

    // The converter sees the value r_log is about to take, so its registered
    // output always matches r_log and is valid at the next clk_en, whatever the duty.
    assign w_chSlot  = (r_slot < SW'(CH));
    assign w_logNext = (clk_en && w_chSlot) ? w_logSel : r_log;

    jt49_exp u_exp (
        .clk  (clk),
        .rst_n(rst_n),
        .comp (COMP),
        .din  (w_logNext),
        .dout (w_lin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot   <= '0;
            r_log    <= 5'd0;
            r_acc    <= '0;
            r_sound  <= '0;
            r_linOut <= '0;
            r_sample <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            if (clk_en) begin
                if (w_chSlot) begin
                    r_log <= w_logSel;
                end
                if (r_slot == '0) begin
                    r_sound  <= r_acc;
                    r_acc    <= '0;
                    r_sample <= 1'b1;
                end else begin
                    r_acc <= r_acc + AW'(w_lin);
                    for (int k = 0; k < CH; k++) begin
                        if (r_slot == SW'(k + 1)) begin
                            r_linOut[8*k +: 8] <= w_lin;
                        end
                    end
                end
                r_slot <= (r_slot == SW'(CH)) ? '0 : r_slot + 1'b1;
            end
        end
    end

    assign lin_out = r_linOut;
    assign sound   = r_sound;
    assign sample  = r_sample;
endmodule
